des_fp_out: RTL and testbench

Output stage of the DES decryption datapath. Accepts the round-16 halves (L16, R16) from the round engine, forms the swapped pre-output R16‖L16, applies the final permutation (IP⁻¹), and holds the resulting 64-bit plaintext in an output register with a valid/ready handshake. It is the exit counterpart of the initial-permutation stage at the datapath entry. An optional build adds a byte-serial plaintext stream in place of the parallel output.

---
 rtl/des_fp_out.sv | 93 +++++++++
 tb/tb_des_fp_out.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/des_fp_out.sv
// des_fp_out: DES output stage - swaps L16/R16, applies IP^-1 and registers the plaintext.
// Defining DES_FP_BYTE_STREAM_EN replaces the parallel output with a byte-serial IDLE/SEND streamer.
module des_fp_out (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:32] left_in,
   input  logic [1:32] right_in,
`ifdef DES_FP_BYTE_STREAM_EN
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic [7:0]  byte_out,
   output logic        byte_last
`else
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:64] plaintext
`endif
);
   logic [1:64] pre;
   logic [1:64] perm;
   logic        accept;
   assign pre = {right_in, left_in};
   // IP^-1 row r, column c picks pre-output bit 40/8 + 8*(c/2) - r (even/odd columns)
   for (genvar r = 0; r < 8; r++) begin : g_row
      for (genvar c = 0; c < 8; c++) begin : g_col
         assign perm[8*r+c+1] = pre[((c % 2) != 0 ? 8 : 40) + 8*(c/2) - r];
      end
   end
   assign accept = in_valid && in_ready;
`ifdef DES_FP_BYTE_STREAM_EN
   typedef enum logic {IDLE, SEND} state_t;
   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [1:64] shreg_q, shreg_d;
   // state, byte counter and shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
      end
   end
   // a new word reloads (even on the last-byte handshake); otherwise a taken byte shifts out
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      if (accept) begin
         state_d = SEND;
         cnt_d   = 3'd0;
         shreg_d = perm;
      end else if (state_q == SEND && byte_ready) begin
         state_d = (cnt_q == 3'd7) ? IDLE : SEND;
         cnt_d   = cnt_q + 3'd1;
         shreg_d = {shreg_q[9:64], 8'h00};
      end
   end
   // byte presentation and input acceptance
   always_comb begin
      byte_valid = (state_q == SEND);
      byte_out   = shreg_q[1:8];
      byte_last  = (state_q == SEND) && (cnt_q == 3'd7);
      in_ready   = (state_q == IDLE) || ((cnt_q == 3'd7) && byte_ready);
   end
`else
   logic        out_valid_q, out_valid_d;
   logic [1:64] plaintext_q, plaintext_d;
   assign in_ready  = !out_valid_q || out_ready;
   assign out_valid = out_valid_q;
   assign plaintext = plaintext_q;
   // load on accept (wins over drain), clear valid on drain
   always_comb begin
      out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
      plaintext_d = accept ? perm : plaintext_q;
   end
   // single-entry output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         plaintext_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         plaintext_q <= plaintext_d;
      end
   end
`endif
endmodule

// File: tb/tb_des_fp_out.sv
// tb_des_fp_out: directed and throttled-random checks of the parallel des_fp_out build
module tb_des_fp_out;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:32] left_in;
   logic [1:32] right_in;
   logic        out_valid;
   logic        out_ready;
   logic [1:64] plaintext;
   int          n_vec = 0;
   int          n_err = 0;
   localparam int FP [64] = '{40, 8, 48, 16, 56, 24, 64, 32,
                              39, 7, 47, 15, 55, 23, 63, 31,
                              38, 6, 46, 14, 54, 22, 62, 30,
                              37, 5, 45, 13, 53, 21, 61, 29,
                              36, 4, 44, 12, 52, 20, 60, 28,
                              35, 3, 43, 11, 51, 19, 59, 27,
                              34, 2, 42, 10, 50, 18, 58, 26,
                              33, 1, 41,  9, 49, 17, 57, 25};
   des_fp_out dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .left_in   (left_in),
      .right_in  (right_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .plaintext (plaintext)
   );
   always #5 clk = ~clk;
   function automatic logic [63:0] fp_model(input logic [31:0] l, input logic [31:0] r);
      logic [63:0] p;
      logic [63:0] q;
      p = {r, l};
      q = '0;
      for (int k = 1; k <= 64; k++) q[64-k] = p[64-FP[k-1]];
      return q;
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic one(input string tag, input logic [31:0] l, input logic [31:0] r, input logic [63:0] exp);
      in_valid  = 1'b1;
      left_in   = l;
      right_in  = r;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_data"}, plaintext, exp);
      chk({tag, "_inrdy"}, 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_drain"}, 64'(out_valid), 64'd0);
   endtask
   initial begin
      logic [31:0] sl [4];
      logic [31:0] sr [4];
      logic [63:0] se [4];
      logic        mv;
      logic [63:0] mp;
      int          nacc;
      int          cyc;
      sl = '{32'hF0AAF0AA, 32'h00000000, 32'h00000001, 32'h80000000};
      sr = '{32'hCC00CCFF, 32'h80000000, 32'h00000000, 32'h00000000};
      se = '{64'h0123456789ABCDEF, 64'h0000000000000040, 64'h0200000000000000, 64'h0000000000000080};
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      left_in   = '0;
      right_in  = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", plaintext, 64'd0);
      chk("rst_inrdy", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);
      one("known", 32'hF0AAF0AA, 32'hCC00CCFF, 64'h0123456789ABCDEF);
      one("r_msb", 32'h00000000, 32'h80000000, 64'h0000000000000040);
      one("l_lsb", 32'h00000001, 32'h00000000, 64'h0200000000000000);
      one("r_lsb", 32'h00000000, 32'h00000001, 64'h0100000000000000);
      one("l_msb", 32'h80000000, 32'h00000000, 64'h0000000000000080);
      // back-pressure: one word taken, the next waits for the drain cycle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      left_in   = 32'hF0AAF0AA;
      right_in  = 32'hCC00CCFF;
      @(negedge clk);
      left_in  = 32'h00000000;
      right_in = 32'h80000000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_inrdy", 64'(in_ready), 64'd0);
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_hold", plaintext, 64'h0123456789ABCDEF);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_inrdy", 64'(in_ready), 64'd1);
      @(negedge clk);
      chk("bp_next_valid", 64'(out_valid), 64'd1);
      chk("bp_next_data", plaintext, 64'h0000000000000040);
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_empty", 64'(out_valid), 64'd0);
      // streaming at full rate
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         left_in  = sl[i];
         right_in = sr[i];
         @(negedge clk);
         chk("stream_valid", 64'(out_valid), 64'd1);
         chk("stream_data", plaintext, se[i]);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("stream_end", 64'(out_valid), 64'd0);
      // asynchronous reset discards a held word
      out_ready = 1'b0;
      in_valid  = 1'b1;
      left_in   = 32'hF0AAF0AA;
      right_in  = 32'hCC00CCFF;
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("async_rst_data", plaintext, 64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", 64'(out_valid), 64'd0);
      chk("post_rst_data", plaintext, 64'd0);
      // throttled random against the table-driven model
      mv   = 1'b0;
      mp   = '0;
      nacc = 0;
      cyc  = 0;
      while (nacc < 1000 && cyc < 20000) begin
         logic acc;
         chk("rnd_valid", 64'(out_valid), 64'(mv));
         if (mv) chk("rnd_data", plaintext, mp);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         left_in   = $urandom;
         right_in  = $urandom;
         #1 chk("rnd_inrdy", 64'(in_ready), 64'(!mv || out_ready));
         acc = in_valid && (!mv || out_ready);
         if (acc) begin
            mp = fp_model(left_in, right_in);
            mv = 1'b1;
            nacc++;
         end else if (out_ready) begin
            mv = 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      chk("rnd_accepted", 64'(nacc), 64'd1000);
      chk("rnd_last_valid", 64'(out_valid), 64'(mv));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
